pipe_addsub_flags: RTL and testbench
====================================

Name: pipe_addsub_flags

Overview:
- Parametrised, pipelined two's-complement adder/subtractor with a status-flag output.
- Operands are split into CHUNK-bit slices. One slice is summed per pipeline stage, and the inter-slice carry is registered between stages.
- Adds subtract mode, a zero flag and valid/ready flow control on both sides.
- Sits between an operand-issuing datapath stage and the ALU result/flag writeback.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CHUNK, 8, slice width per pipeline stage. WIDTH % CHUNK must be 0; otherwise elaboration fails via a static assertion.
- STAGES, WIDTH/CHUNK, derived local parameter and the latency in cycles. Not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand x.
- b  in  WIDTH  operand y.
- sub  in  1  0 = a+b+c_in; 1 = a-b.
- c_in  in  1  carry-in, add mode only.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cf  out  1  carry out of the MSB.
- sf  out  1  sum[WIDTH-1].
- of  out  1  signed overflow.
- zf  out  1  sum == 0.

Behaviour:
- Operand transform at input:
  - b_eff = sub ? ~b : b.
  - cin_eff = sub ? 1 : c_in. c_in is ignored when sub=1.
- Pipeline:
  - STAGES register stages, each holding a valid bit, the skewed remaining operand slices, the partial sum slices computed so far, and the carry.
  - Stage k (0-based) computes slice k: bits [k*CHUNK +: CHUNK] of a + b_eff + carry_k, with carry_0 = cin_eff.
  - Stage k forwards carry_{k+1}.
  - All arithmetic within a slice is CHUNK+1 bits wide; the MSB is the carry.
- Latency: a beat accepted in cycle t appears at the outputs in cycle t+STAGES, given no stalls.
- Flags are formed in the last stage and registered with sum:
  - cf = final carry. In sub mode, cf=1 means no borrow (a >= b unsigned).
  - sf = sum[WIDTH-1].
  - of = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
  - zf = (sum == 0).
- Flow control uses a global stall, with no bubble collapsing:
  - advance = !out_valid || out_ready.
  - in_ready = advance (combinational).
  - When advance=1, every stage shifts one position. Stage 0 loads in_valid && in_ready along with the operands.
  - When advance=0, all stage registers and all outputs hold. An input beat presented while in_ready=0 is not captured; the producer holds it.
- Output handshake:
  - A result transfers when out_valid && out_ready.
  - sum and the flags stay stable while out_valid=1 and out_ready=0.
  - Results leave in issue order. No beat is dropped or duplicated.
- Reset: rst_n low, asserted asynchronously at any time including mid-stream, clears:
  - all stage valid bits, so out_valid=0;
  - sum=0, cf=0, sf=0, of=0, zf=0;
  - all internal carries and partials.
  - In-flight beats are discarded.
  - in_ready=1 from the first cycle after release. Release is synchronous to clk.
- Boundary cases:
  - STAGES=1 (CHUNK=WIDTH) degenerates to a single registered adder with latency 1.
  - A simultaneous output pop and input push in one cycle is legal and sustains 1 beat/cycle.
  - Bubbles (in_valid=0) propagate as invalid stages.
  - Data and flags on a stage with valid=0 are don't-care internally, but outputs hold their last value when out_valid=0 (post-reset: 0).

Test Plan:
- WIDTH=32, CHUNK=8, add a=0x7FFFFFFF, b=0x00000001, c_in=0 -> after 4 cycles: sum=0x80000000, cf=0, sf=1, of=1, zf=0.
- Add a=0xFFFFFFFF, b=0x00000001, c_in=0 -> sum=0x00000000, cf=1, sf=0, of=0, zf=1. Then add a=1, b=2, c_in=1 -> sum=0x00000004, all flags 0.
- Subtract a=5, b=7 -> sum=0xFFFFFFFE, cf=0, sf=1, of=0, zf=0. Subtract a=0x80000000, b=1 -> sum=0x7FFFFFFF, cf=1, sf=0, of=1, zf=0. Subtract a=b=0x1234 with c_in=1 -> sum=0, cf=1, zf=1.
- Stream 10 back-to-back random beats; hold out_ready=0 for cycles 6-8 -> in_ready=0 in the same cycles, outputs stable, all 10 results emitted in order matching a reference model, with zero loss or duplication.
- Issue 3 beats, assert rst_n=0 asynchronously mid-cycle before any output -> out_valid and all flags drop to 0 immediately. After release, no stale beat emerges, and a new beat completes with 4-cycle latency.
- Re-run the first three scenarios with WIDTH=16, CHUNK=4 and with WIDTH=32, CHUNK=32 -> latency 4 and 1 respectively, with equivalent flag results. WIDTH=30, CHUNK=8 -> elaboration error.

Source files
------------

// File: rtl/pipe_addsub_flags.sv
// Pipelined two's-complement adder/subtractor: one CHUNK-bit slice per stage,
// carry registered between stages, flags (cf/sf/of/zf) registered with the sum.
module pipe_addsub_flags #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cf,
  output logic             sf,
  output logic             of,
  output logic             zf
);

  localparam int STAGES = WIDTH / CHUNK;

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("pipe_addsub_flags: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  // Handshake: a beat enters when in_valid && in_ready, a result leaves when
  // out_valid && out_ready. One global advance moves every stage together, so
  // a stalled output freezes the whole pipe and in_ready drops in that cycle.
  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign b_eff    = sub ? ~b : b;
  assign cin_eff  = sub ? 1'b1 : c_in;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Stage k consumes the low slice of what is left of the operands and
    // forwards only the still-unsummed upper slices.
    localparam int IN_W  = WIDTH - k * CHUNK;
    localparam int REM_W = IN_W - CHUNK;
    localparam int SUM_W = (k + 1) * CHUNK;

    logic [IN_W-1:0]  a_src;
    logic [IN_W-1:0]  b_src;
    logic             c_src;
    logic             v_src;
    logic [CHUNK:0]   slice;
    logic [SUM_W-1:0] s_next;

    logic             v_r;
    logic             c_r;
    logic [SUM_W-1:0] s_r;

    assign slice = {1'b0, a_src[CHUNK-1:0]} + {1'b0, b_src[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_src};

    if (k == 0) begin : g_src
      assign a_src  = a;
      assign b_src  = b_eff;
      assign c_src  = cin_eff;
      assign v_src  = in_valid && in_ready;
      assign s_next = slice[CHUNK-1:0];
    end else begin : g_src
      assign a_src  = g_stage[k-1].g_fwd.a_r;
      assign b_src  = g_stage[k-1].g_fwd.b_r;
      assign c_src  = g_stage[k-1].c_r;
      assign v_src  = g_stage[k-1].v_r;
      assign s_next = {slice[CHUNK-1:0], g_stage[k-1].s_r};
    end

    // Data only loads under a valid beat so the last stage holds its result
    // across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_r <= 1'b0;
        c_r <= 1'b0;
        s_r <= '0;
      end else if (advance) begin
        v_r <= v_src;
        if (v_src) begin
          c_r <= slice[CHUNK];
          s_r <= s_next;
        end
      end
    end

    if (REM_W > 0) begin : g_fwd
      logic [REM_W-1:0] a_r;
      logic [REM_W-1:0] b_r;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_r <= '0;
          b_r <= '0;
        end else if (advance && v_src) begin
          a_r <= a_src[IN_W-1:CHUNK];
          b_r <= b_src[IN_W-1:CHUNK];
        end
      end
    end else begin : g_last
      // Top slice of a_src/b_src carries the operand sign bits.
      logic of_r;
      logic zf_r;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          of_r <= 1'b0;
          zf_r <= 1'b0;
        end else if (advance && v_src) begin
          of_r <= (a_src[CHUNK-1] == b_src[CHUNK-1]) && (slice[CHUNK-1] != a_src[CHUNK-1]);
          zf_r <= (s_next == '0);
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_r;
  assign sum       = g_stage[STAGES-1].s_r;
  assign cf        = g_stage[STAGES-1].c_r;
  assign sf        = g_stage[STAGES-1].s_r[WIDTH-1];
  assign of        = g_stage[STAGES-1].g_last.of_r;
  assign zf        = g_stage[STAGES-1].g_last.zf_r;

endmodule

// File: tb/tb_pipe_addsub_flags.sv
// Bench for pipe_addsub_flags: three configurations (32/8, 16/4, 32/32) driven
// in lockstep with directed vectors, a stalled stream and a mid-stream reset.
module tb_pipe_addsub_flags;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        sub;
  logic        c_in;
  logic        out_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [15:0] a16;
  logic [15:0] b16;

  logic        in_ready_p4, ov_p4, cf_p4, sf_p4, of_p4, zf_p4;
  logic [31:0] sum_p4;
  logic        in_ready_n4, ov_n4, cf_n4, sf_n4, of_n4, zf_n4;
  logic [15:0] sum_n4;
  logic        in_ready_p1, ov_p1, cf_p1, sf_p1, of_p1, zf_p1;
  logic [31:0] sum_p1;

  int n_cmp;
  int n_bad;

  pipe_addsub_flags #(.WIDTH(32), .CHUNK(8)) u_p4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_p4),
    .a(a), .b(b), .sub(sub), .c_in(c_in), .out_valid(ov_p4), .out_ready(out_ready),
    .sum(sum_p4), .cf(cf_p4), .sf(sf_p4), .of(of_p4), .zf(zf_p4)
  );

  pipe_addsub_flags #(.WIDTH(16), .CHUNK(4)) u_n4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_n4),
    .a(a16), .b(b16), .sub(sub), .c_in(c_in), .out_valid(ov_n4), .out_ready(out_ready),
    .sum(sum_n4), .cf(cf_n4), .sf(sf_n4), .of(of_n4), .zf(zf_n4)
  );

  pipe_addsub_flags #(.WIDTH(32), .CHUNK(32)) u_p1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_p1),
    .a(a), .b(b), .sub(sub), .c_in(c_in), .out_valid(ov_p1), .out_ready(out_ready),
    .sum(sum_p1), .cf(cf_p1), .sf(sf_p1), .of(of_p1), .zf(zf_p1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        sub;
    logic        cin;
    logic [31:0] s32;
    logic [15:0] s16;
    logic [3:0]  fl;  // {cf, sf, of, zf}
  } vec_t;

  vec_t vecs[9];

  logic [35:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [35:0] ref_model(input logic [31:0] x, input logic [31:0] y,
                                            input logic s, input logic ci);
    logic [31:0] be;
    logic        c0;
    logic [32:0] r;
    be = s ? ~y : y;
    c0 = s ? 1'b1 : ci;
    r  = {1'b0, x} + {1'b0, be} + {32'b0, c0};
    return {r[32], r[31], (x[31] == be[31]) && (r[31] != x[31]), r[31:0] == 32'h0, r[31:0]};
  endfunction

  // One isolated beat into all three instances; measures latency and result.
  task automatic run_vec(input int i);
    int          lat_p4, lat_n4, lat_p1;
    logic [35:0] got_p4, got_p1;
    logic [19:0] got_n4;
    lat_p4 = 0; lat_n4 = 0; lat_p1 = 0;
    got_p4 = '0; got_n4 = '0; got_p1 = '0;
    @(negedge clk);
    a = vecs[i].a; b = vecs[i].b; a16 = vecs[i].a16; b16 = vecs[i].b16;
    sub = vecs[i].sub; c_in = vecs[i].cin;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (lat_p4 == 0 && ov_p4) begin lat_p4 = n; got_p4 = {cf_p4, sf_p4, of_p4, zf_p4, sum_p4}; end
      if (lat_n4 == 0 && ov_n4) begin lat_n4 = n; got_n4 = {cf_n4, sf_n4, of_n4, zf_n4, sum_n4}; end
      if (lat_p1 == 0 && ov_p1) begin lat_p1 = n; got_p1 = {cf_p1, sf_p1, of_p1, zf_p1, sum_p1}; end
    end
    chk($sformatf("vec%0d_p4_latency", i), lat_p4, 4);
    chk($sformatf("vec%0d_p4_sum", i), got_p4[31:0], vecs[i].s32);
    chk($sformatf("vec%0d_p4_flags", i), got_p4[35:32], vecs[i].fl);
    chk($sformatf("vec%0d_n4_latency", i), lat_n4, 4);
    chk($sformatf("vec%0d_n4_sum", i), got_n4[15:0], vecs[i].s16);
    chk($sformatf("vec%0d_n4_flags", i), got_n4[19:16], vecs[i].fl);
    chk($sformatf("vec%0d_p1_latency", i), lat_p1, 1);
    chk($sformatf("vec%0d_p1_sum", i), got_p1[31:0], vecs[i].s32);
    chk($sformatf("vec%0d_p1_flags", i), got_p1[35:32], vecs[i].fl);
  endtask

  initial begin
    logic [31:0] sa[10];
    logic [31:0] sb[10];
    logic        ss[10];
    logic        sc[10];
    logic [35:0] obs, hold_val, exp;
    logic        stall_prev, acc;
    int          cyc, sent, got;

    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sub = 1'b0; c_in = 1'b0; a = '0; b = '0; a16 = '0; b16 = '0;

    vecs[0] = '{32'h7FFFFFFF, 32'h00000001, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 32'h80000000, 16'h8000, 4'b0110};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 32'h00000000, 16'h0000, 4'b1001};
    vecs[2] = '{32'h00000001, 32'h00000002, 16'h0001, 16'h0002, 1'b0, 1'b1, 32'h00000004, 16'h0004, 4'b0000};
    vecs[3] = '{32'h00000005, 32'h00000007, 16'h0005, 16'h0007, 1'b1, 1'b0, 32'hFFFFFFFE, 16'hFFFE, 4'b0100};
    vecs[4] = '{32'h80000000, 32'h00000001, 16'h8000, 16'h0001, 1'b1, 1'b0, 32'h7FFFFFFF, 16'h7FFF, 4'b1010};
    vecs[5] = '{32'h00001234, 32'h00001234, 16'h1234, 16'h1234, 1'b1, 1'b1, 32'h00000000, 16'h0000, 4'b1001};
    vecs[6] = '{32'h12345678, 32'h0F0F0F0F, 16'h5678, 16'h0F0F, 1'b0, 1'b0, 32'h21436587, 16'h6587, 4'b0000};
    vecs[7] = '{32'h80000000, 32'h80000000, 16'h8000, 16'h8000, 1'b0, 1'b0, 32'h00000000, 16'h0000, 4'b1011};
    vecs[8] = '{32'h000000FF, 32'h00000100, 16'h00FF, 16'h0100, 1'b1, 1'b0, 32'hFFFFFFFF, 16'hFFFF, 4'b0100};

    // Reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_p4_out", {in_ready_p4, ov_p4, cf_p4, sf_p4, of_p4, zf_p4, sum_p4}, {1'b1, 37'h0});
    chk("reset_n4_out", {in_ready_n4, ov_n4, cf_n4, sf_n4, of_n4, zf_n4, sum_n4}, {1'b1, 21'h0});
    chk("reset_p1_out", {in_ready_p1, ov_p1, cf_p1, sf_p1, of_p1, zf_p1, sum_p1}, {1'b1, 37'h0});

    // Directed vectors
    for (int i = 0; i < 9; i++) run_vec(i);

    // Back-to-back stream with out_ready low in cycles 6..8
    for (int i = 0; i < 10; i++) begin
      sa[i] = $urandom;
      sb[i] = $urandom;
      ss[i] = 1'($urandom_range(0, 1));
      sc[i] = 1'($urandom_range(0, 1));
    end
    exp_q.delete();
    cyc = 0; sent = 0; got = 0; stall_prev = 1'b0; hold_val = '0;
    @(posedge clk);
    #1;
    while (cyc < 40) begin
      out_ready = !(cyc >= 6 && cyc <= 8);
      if (sent < 10) begin
        in_valid = 1'b1;
        a = sa[sent]; b = sb[sent]; sub = ss[sent]; c_in = sc[sent];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      obs = {cf_p4, sf_p4, of_p4, zf_p4, sum_p4};
      if (stall_prev) chk($sformatf("stall_hold_c%0d", cyc), {ov_p4, obs}, {1'b1, hold_val});
      if (cyc >= 6 && cyc <= 8) chk($sformatf("stall_in_ready_c%0d", cyc), in_ready_p4, 1'b0);
      if (ov_p4 && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL stream_extra: got an unexpected result 0x%0h, expected none", obs);
        end else begin
          exp = exp_q.pop_front();
          chk($sformatf("stream_result%0d", got), obs, exp);
          got++;
        end
      end
      stall_prev = ov_p4 && !out_ready;
      hold_val = obs;
      acc = in_valid && in_ready_p4;
      if (acc) exp_q.push_back(ref_model(a, b, sub, c_in));
      @(posedge clk);
      #1;
      if (acc) sent++;
      cyc++;
    end
    chk("stream_count", got, 10);
    chk("stream_leftover", exp_q.size(), 0);

    // Mid-stream asynchronous reset with three beats in flight
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b1; sub = 1'b0; c_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 32'h1000 + i; b = 32'h20; a16 = 16'h100 + 16'(i); b16 = 16'h2;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_p4", {ov_p4, cf_p4, sf_p4, of_p4, zf_p4, sum_p4}, 37'h0);
    chk("async_reset_n4", {ov_n4, cf_n4, sf_n4, of_n4, zf_n4, sum_n4}, 21'h0);
    chk("async_reset_p1", {ov_p1, cf_p1, sf_p1, of_p1, zf_p1, sum_p1}, 37'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk($sformatf("post_reset_idle%0d", n), {in_ready_p4, ov_p4, ov_n4, ov_p1}, 4'b1000);
    end
    run_vec(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
